// File: rtl/voxel_csr_pkg.sv
// rtl/voxel_csr_pkg.sv - register map, response codes and shared helpers for the voxel CSR block
package voxel_csr_pkg;

    localparam int REG_DMA_SRC    = 'h18;
    localparam int REG_DMA_DST    = 'h19;
    localparam int REG_DMA_LEN    = 'h1A;
    localparam int REG_DMA_CMD    = 'h1B;
    localparam int REG_DMA_STATUS = 'h1C;
    localparam int REG_INT_STATUS = 'h20;
    localparam int REG_INT_MASK   = 'h21;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int INT_FRAME_DONE = 0;
    localparam int INT_DMA_DONE   = 1;

    localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_slave_if.sv
// rtl/axil_slave_if.sv - AXI-Lite handshake FSMs exposing a simple register access strobe interface
module axil_slave_if
    import voxel_csr_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    input  logic              wr_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    input  logic              rd_err
);

    wr_state_t wstate, wnext;
    rd_state_t rstate, rnext;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate       <= W_IDLE;
            rstate       <= R_IDLE;
            s_axil_bresp <= RESP_OKAY;
            s_axil_rresp <= RESP_OKAY;
            s_axil_rdata <= '0;
        end else begin
            wstate <= wnext;
            rstate <= rnext;
            if (wr_en) s_axil_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (rd_en) begin
                s_axil_rdata <= rd_data;
                s_axil_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_comb begin
        wnext = wstate;
        case (wstate)
            W_IDLE: if (wr_en) wnext = W_RESP;
            W_RESP: if (s_axil_bready) wnext = W_IDLE;
            default: wnext = W_IDLE;
        endcase
        rnext = rstate;
        case (rstate)
            R_IDLE: if (rd_en) rnext = R_DATA;
            R_DATA: if (s_axil_rready) rnext = R_IDLE;
            default: rnext = R_IDLE;
        endcase
    end

    // Address and data are only taken together, so a lone AW or W simply waits.
    always_comb begin
        wr_en          = 1'b0;
        rd_en          = 1'b0;
        s_axil_bvalid  = 1'b0;
        s_axil_rvalid  = 1'b0;
        if (wstate == W_IDLE) wr_en = !rst && s_axil_awvalid && s_axil_wvalid;
        else                  s_axil_bvalid = 1'b1;
        if (rstate == R_IDLE) rd_en = !rst && s_axil_arvalid;
        else                  s_axil_rvalid = 1'b1;
        s_axil_awready = wr_en;
        s_axil_wready  = wr_en;
        s_axil_arready = rd_en;
    end

    assign wr_addr = s_axil_awaddr;
    assign wr_data = s_axil_wdata;
    assign wr_strb = s_axil_wstrb;
    assign rd_addr = s_axil_araddr;

endmodule

// File: rtl/voxel_axil_csr.sv
// rtl/voxel_axil_csr.sv - voxel shell CSR file: DMA programming, W1C interrupt status, IRQ and MSI
module voxel_axil_csr
    import voxel_csr_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          DMA_ADDR_W = 28,
    parameter int          LEN_W      = 24,
    parameter logic [31:0] BAD_DATA   = BAD_DATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_W-1:0]     s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [DMA_ADDR_W-1:0] dma_src,
    output logic [DMA_ADDR_W-1:0] dma_dst,
    output logic [LEN_W-1:0]      dma_len,
    output logic                  dma_start,
    input  logic                  dma_busy,
    input  logic                  dma_done,
    input  logic                  frame_done,
    output logic                  irq_out,
    output logic                  msi_pulse
);

    logic              wr_en, wr_err, rd_en, rd_err;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data, rd_data;
    logic [3:0]        wr_strb;
    logic              dma_err, irq_q;
    logic [1:0]        int_status, int_mask, int_set, int_clr;

    axil_slave_if #(.ADDR_W(ADDR_W)) u_if (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
    );

    always_comb begin
        rd_data = BAD_DATA;
        rd_err  = 1'b0;
        case (rd_addr)
            ADDR_W'(REG_DMA_SRC):    rd_data = 32'(dma_src);
            ADDR_W'(REG_DMA_DST):    rd_data = 32'(dma_dst);
            ADDR_W'(REG_DMA_LEN):    rd_data = 32'(dma_len);
            ADDR_W'(REG_DMA_CMD):    rd_data = '0;
            ADDR_W'(REG_DMA_STATUS): rd_data = {30'b0, dma_err, dma_busy};
            ADDR_W'(REG_INT_STATUS): rd_data = {30'b0, int_status};
            ADDR_W'(REG_INT_MASK):   rd_data = {30'b0, int_mask};
            default:                 rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        wr_err = 1'b0;
        case (wr_addr)
            ADDR_W'(REG_DMA_SRC), ADDR_W'(REG_DMA_DST), ADDR_W'(REG_DMA_LEN),
            ADDR_W'(REG_DMA_CMD), ADDR_W'(REG_DMA_STATUS),
            ADDR_W'(REG_INT_STATUS), ADDR_W'(REG_INT_MASK): wr_err = 1'b0;
            default:                                         wr_err = 1'b1;
        endcase
    end

    // New events take priority over a W1C landing in the same cycle.
    always_comb begin
        int_set                 = '0;
        int_set[INT_DMA_DONE]   = dma_done;
        int_set[INT_FRAME_DONE] = frame_done;
        int_clr = (wr_en && wr_addr == ADDR_W'(REG_INT_STATUS) && wr_strb[0]) ? wr_data[1:0] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dma_src    <= '0;
            dma_dst    <= '0;
            dma_len    <= '0;
            dma_start  <= 1'b0;
            dma_err    <= 1'b0;
            int_status <= '0;
            int_mask   <= '0;
            irq_out    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            dma_start  <= 1'b0;
            int_status <= (int_status & ~int_clr) | int_set;
            irq_out    <= |(int_status & int_mask);
            irq_q      <= irq_out;
            if (wr_en) begin
                case (wr_addr)
                    ADDR_W'(REG_DMA_SRC):
                        dma_src <= DMA_ADDR_W'(apply_strb(32'(dma_src), wr_data, wr_strb));
                    ADDR_W'(REG_DMA_DST):
                        dma_dst <= DMA_ADDR_W'(apply_strb(32'(dma_dst), wr_data, wr_strb));
                    ADDR_W'(REG_DMA_LEN):
                        dma_len <= LEN_W'(apply_strb(32'(dma_len), wr_data, wr_strb));
                    ADDR_W'(REG_INT_MASK):
                        int_mask <= 2'(apply_strb({30'b0, int_mask}, wr_data, wr_strb));
                    ADDR_W'(REG_DMA_CMD):
                        if (wr_strb[0] && wr_data[0]) begin
                            if (dma_busy) dma_err   <= 1'b1;
                            else          dma_start <= 1'b1;
                        end
                    ADDR_W'(REG_DMA_STATUS):
                        if (wr_strb[0] && wr_data[1]) dma_err <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign msi_pulse = irq_out & ~irq_q;

endmodule

// File: tb/tb_voxel_axil_csr.sv
// tb/tb_voxel_axil_csr.sv - directed self-checking bench for voxel_axil_csr
module tb_voxel_axil_csr;
    logic        clk, rst;
    logic [15:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [27:0] dma_src, dma_dst;
    logic [23:0] dma_len;
    logic        dma_start, dma_busy, dma_done, frame_done, irq_out, msi_pulse;

    int checks = 0;
    int errors = 0;
    logic        start_seen, start_after;
    logic [1:0]  resp;
    logic [31:0] data;

    voxel_axil_csr dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len), .dma_start(dma_start),
        .dma_busy(dma_busy), .dma_done(dma_done), .frame_done(frame_done),
        .irq_out(irq_out), .msi_pulse(msi_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; n = 0;
        #1;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL aw_timeout obs=%0d exp=<20", n);
        end
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        start_seen = dma_start;
        chk("bvalid", 32'(bvalid), 32'd1);
        r = bresp;
        bready = 1'b1;
        @(posedge clk); @(negedge clk);
        bready = 1'b0;
        start_after = dma_start;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b0; n = 0;
        #1;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL ar_timeout obs=%0d exp=<20", n);
        end
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid", 32'(rvalid), 32'd1);
        d = rdata; r = rresp;
        rready = 1'b1;
        @(posedge clk); @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; bready = 0;
        arvalid = 0; rready = 0; wdata = '0; wstrb = '0;
        dma_busy = 0; dma_done = 0; frame_done = 0;
        repeat (3) @(negedge clk);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", 32'(irq_out), 0);
        chk("rst_start", 32'(dma_start), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: program SRC/DST/LEN and read back
        axi_write(16'h18, 32'h0, 4'hF, resp);   chk("src_bresp", 32'(resp), 0);
        axi_write(16'h19, 32'h100, 4'hF, resp); chk("dst_bresp", 32'(resp), 0);
        axi_write(16'h1A, 32'h40, 4'hF, resp);  chk("len_bresp", 32'(resp), 0);
        axi_read(16'h18, data, resp); chk("src_rd", data, 32'h0);   chk("src_rresp", 32'(resp), 0);
        axi_read(16'h19, data, resp); chk("dst_rd", data, 32'h100); chk("dst_rresp", 32'(resp), 0);
        axi_read(16'h1A, data, resp); chk("len_rd", data, 32'h40);
        chk("dma_dst_out", 32'(dma_dst), 32'h100);
        chk("dma_len_out", 32'(dma_len), 32'h40);

        // 2: start, DMA completion, irq + msi
        axi_write(16'h21, 32'h3, 4'hF, resp);
        axi_read(16'h21, data, resp); chk("mask_rd", data, 32'h3);
        axi_write(16'h1B, 32'h1, 4'hF, resp);
        chk("start_pulse", 32'(start_seen), 1);
        chk("start_one_cycle", 32'(start_after), 0);
        axi_read(16'h1B, data, resp); chk("cmd_rd_zero", data, 0);
        dma_done = 1'b1;
        @(negedge clk); dma_done = 1'b0;
        chk("irq_lag", 32'(irq_out), 0);
        @(negedge clk);
        chk("irq_rise", 32'(irq_out), 1);
        chk("msi_rise", 32'(msi_pulse), 1);
        @(negedge clk);
        chk("msi_one_cycle", 32'(msi_pulse), 0);
        chk("irq_hold", 32'(irq_out), 1);
        axi_read(16'h20, data, resp); chk("int_status_dma", data, 32'h2);

        // 3: W1C clear, then same-cycle set + clear
        axi_write(16'h20, 32'h2, 4'h1, resp);
        chk("irq_drop", 32'(irq_out), 0);
        axi_read(16'h20, data, resp); chk("int_status_clr", data, 0);
        awaddr = 16'h20; wdata = 32'h2; wstrb = 4'h1; awvalid = 1; wvalid = 1; bready = 1; dma_done = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; dma_done = 0;
        chk("w1c_race_bvalid", 32'(bvalid), 1);
        @(negedge clk); bready = 0;
        axi_read(16'h20, data, resp); chk("set_wins", data, 32'h2);
        chk("irq_after_race", 32'(irq_out), 1);

        // 4: start while busy -> sticky err; clear via DMA_STATUS bit1
        dma_busy = 1'b1;
        axi_write(16'h1B, 32'h1, 4'hF, resp);
        chk("busy_no_start", 32'(start_seen), 0);
        axi_read(16'h1C, data, resp); chk("status_err_busy", data, 32'h3);
        axi_write(16'h1C, 32'h2, 4'hF, resp); chk("status_wr_bresp", 32'(resp), 0);
        axi_read(16'h1C, data, resp); chk("err_cleared", data, 32'h1);
        dma_busy = 1'b0;
        axi_write(16'h1B, 32'h1, 4'h2, resp);
        chk("cmd_lane0_off", 32'(start_seen), 0);
        axi_read(16'h1C, data, resp); chk("status_idle", data, 0);

        // 5: strobes, field widths, unmapped access
        axi_write(16'h18, 32'hFFFFFFFF, 4'h1, resp);
        axi_read(16'h18, data, resp); chk("src_strb", data, 32'hFF);
        axi_write(16'h1A, 32'hFFFFFFFF, 4'hF, resp);
        axi_read(16'h1A, data, resp); chk("len_width", data, 32'h00FFFFFF);
        axi_read(16'h55, data, resp);
        chk("bad_rdata", data, 32'hDEADBEEF); chk("bad_rresp", 32'(resp), 2);
        axi_write(16'h55, 32'h12345678, 4'hF, resp); chk("bad_bresp", 32'(resp), 2);
        axi_read(16'h18, data, resp); chk("src_untouched", data, 32'hFF);
        chk("dma_src_out", 32'(dma_src), 32'hFF);

        // 6: held responses, then reset mid-hold
        awaddr = 16'h19; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        araddr = 16'h18; arvalid = 1; rready = 0;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        for (int i = 0; i < 10; i++) begin
            chk("hold_bvalid", 32'(bvalid), 1);
            chk("hold_bresp", 32'(bresp), 0);
            chk("hold_rvalid", 32'(rvalid), 1);
            chk("hold_rdata", rdata, 32'hFF);
            @(negedge clk);
        end
        chk("pre_rst_irq", 32'(irq_out), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bvalid", 32'(bvalid), 0);
        chk("mid_rst_rvalid", 32'(rvalid), 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_irq", 32'(irq_out), 0);
        chk("mid_rst_msi", 32'(msi_pulse), 0);
        chk("mid_rst_src", 32'(dma_src), 0);
        chk("mid_rst_dst", 32'(dma_dst), 0);
        chk("mid_rst_start", 32'(dma_start), 0);
        rst = 1'b0;
        @(negedge clk);
        axi_read(16'h19, data, resp); chk("dst_after_rst", data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
